seg7_count_display: RTL and testbench

Display stage that consumes the 4-bit `count` from `synchronous_counter` and drives the Basys 3 four-digit common-anode seven-segment display. It shows the value as a decimal 0..15 on the two rightmost digits and time-multiplexes the anodes. It also snapshots `count` once per refresh frame so a display frame never mixes two counter values.

---
 rtl/seg7_count_display.sv | 103 ++++++++++
 tb/tb_seg7_count_display.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg7_count_display.sv
// Four-digit common-anode seven-segment driver showing a 4-bit count as decimal 0..15.
// The count is snapshotted once per refresh frame so a frame never mixes two values.
module seg7_count_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int             PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]  PONE = PW'(1);
  localparam logic [6:0]     SEG_OFF = 7'b1111111;
  localparam logic [3:0]     AN_OFF  = 4'b1111;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_snap;
  logic          r_frame;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_tick;
  logic          w_tens;
  logic [3:0]    w_ones;

  function automatic logic [6:0] f_pat(input logic [3:0] d);
    case (d)
      4'd0:    f_pat = 7'b1000000;
      4'd1:    f_pat = 7'b1111001;
      4'd2:    f_pat = 7'b0100100;
      4'd3:    f_pat = 7'b0110000;
      4'd4:    f_pat = 7'b0011001;
      4'd5:    f_pat = 7'b0010010;
      4'd6:    f_pat = 7'b0000010;
      4'd7:    f_pat = 7'b1111000;
      4'd8:    f_pat = 7'b0000000;
      4'd9:    f_pat = 7'b0010000;
      default: f_pat = 7'b1111111;
    endcase
  endfunction

  assign w_tick = (r_presc == PMAX);
  assign w_tens = (r_snap >= 4'd10);
  assign w_ones = w_tens ? (r_snap - 4'd10) : r_snap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_presc <= '0;
    else      r_presc <= w_tick ? '0 : (r_presc + PONE);
  end

  // Index wraps 3->0 naturally; the capture shares that same tick edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= 2'd0;
      r_snap  <= 4'd0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_tick && (r_idx == 2'd3);
      if (w_tick) r_idx <= r_idx + 2'd1;
      if (w_tick && (r_idx == 2'd3)) r_snap <= count;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      case (r_idx)
        2'd0: begin
          r_an  <= 4'b1110;
          r_seg <= f_pat(w_ones);
        end
        2'd1: begin
          if (!w_tens && BLANK_LZ) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
          end else begin
            r_an  <= 4'b1101;
            r_seg <= f_pat({3'b000, w_tens});
          end
        end
        default: begin
          r_an  <= AN_OFF;
          r_seg <= SEG_OFF;
        end
      endcase
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign frame = r_frame;
  assign dp    = 1'b1;

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display at REFRESH_DIV=4, with BLANK_LZ=1 and BLANK_LZ=0 instances.
module tb_seg7_count_display;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic [3:0] an, an_lz;
  logic [6:0] seg, seg_lz;
  logic       dp, dp_lz;
  logic       frame, frame_lz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg7_count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .count(count),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  seg7_count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_lz (
    .clk(clk), .rst(rst), .count(count),
    .an(an_lz), .seg(seg_lz), .dp(dp_lz), .frame(frame_lz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Sampled at the negedge following posedge number e after reset release.
  task automatic go(input int e);
    while (cyc < e) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] ea, input logic [6:0] es);
    chk({tag, ".an"}, 16'(an), 16'(ea));
    chk({tag, ".seg"}, 16'(seg), 16'(es));
  endtask

  task automatic chk_lz(input string tag, input logic [3:0] ea, input logic [6:0] es);
    chk({tag, ".an_lz"}, 16'(an_lz), 16'(ea));
    chk({tag, ".seg_lz"}, 16'(seg_lz), 16'(es));
  endtask

  initial begin
    rst   = 1'b0;
    count = 4'd0;
    // Reset held: outputs stay off while count toggles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      count = 4'(i * 5 + 3);
      #1;
      chk_disp("rst_hold", 4'b1111, 7'b1111111);
      chk("rst_dp", 16'(dp), 16'd1);
      chk("rst_frame", 16'(frame), 16'd0);
    end
    @(negedge clk);
    rst = 1'b1; cyc = 0; count = 4'd7;

    go(1);   chk_disp("first_out", 4'b1110, 7'b1000000);
             chk("first_frame", 16'(frame), 16'd0);
    go(15);  chk("frame_pre16", 16'(frame), 16'd0);
    go(16);  chk("frame16", 16'(frame), 16'd1);
    go(17);  chk("frame17", 16'(frame), 16'd0);
             chk_disp("cap7_d0", 4'b1110, 7'b1111000);
             count = 4'd13;
    go(21);  chk_disp("cap7_tens_blank", 4'b1111, 7'b1111111);

    go(33);  chk_disp("cap13_d0", 4'b1110, 7'b0110000);
    go(36);  chk_disp("cap13_d0_end", 4'b1110, 7'b0110000);
    go(37);  chk_disp("cap13_d1", 4'b1101, 7'b1111001);
    go(40);  chk_disp("cap13_d1_end", 4'b1101, 7'b1111001);
             count = 4'd5;
    go(41);  chk_disp("cap13_slot2", 4'b1111, 7'b1111111);
    go(47);  chk("frame47", 16'(frame), 16'd0);
    go(48);  chk("frame48", 16'(frame), 16'd1);

    go(49);  chk_disp("cap5_d0", 4'b1110, 7'b0010010);
    go(53);  chk_disp("cap5_d1", 4'b1111, 7'b1111111);
             chk_lz("cap5_d1_lz", 4'b1101, 7'b1000000);
    go(54);  count = 4'd12;
    go(55);  chk_disp("tear_d1", 4'b1111, 7'b1111111);
             chk_lz("tear_d1_lz", 4'b1101, 7'b1000000);
    go(64);  chk("frame64", 16'(frame), 16'd1);
    go(65);  chk_disp("cap12_d0", 4'b1110, 7'b0100100);
    go(69);  chk_disp("cap12_d1", 4'b1101, 7'b1111001);
             count = 4'd4;

    go(81);  chk_disp("cap4_d0", 4'b1110, 7'b0011001);
             chk_lz("cap4_d0_lz", 4'b1110, 7'b0011001);
    go(85);  chk_disp("cap4_d1", 4'b1111, 7'b1111111);
             chk_lz("cap4_d1_lz", 4'b1101, 7'b1000000);
             count = 4'd15;

    go(97);  chk_disp("cap15_d0", 4'b1110, 7'b0010010);
    go(101); chk_disp("cap15_d1", 4'b1101, 7'b1111001);
             count = 4'd0;
    go(113); chk_disp("cap0_d0", 4'b1110, 7'b1000000);
    go(117); chk_disp("cap0_d1", 4'b1111, 7'b1111111);
             count = 4'd9;
    go(129); chk_disp("cap9_d0", 4'b1110, 7'b0010000);
    go(130);

    // Mid-slot reset: outputs must go off without waiting for a clock edge
    #2 rst = 1'b0;
    #1;
    chk_disp("midrst", 4'b1111, 7'b1111111);
    chk("midrst_frame", 16'(frame), 16'd0);
    @(negedge clk);
    chk_disp("midrst_hold", 4'b1111, 7'b1111111);
    rst = 1'b1; cyc = 0;

    go(1);   chk_disp("rel_snap_clear", 4'b1110, 7'b1000000);
    go(15);  chk("rel_frame15", 16'(frame), 16'd0);
    go(16);  chk("rel_frame16", 16'(frame), 16'd1);
    go(17);  chk_disp("rel_cap9", 4'b1110, 7'b0010000);
             chk("rel_dp", 16'(dp), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
